// File: rtl/spi_frame_sequencer.sv
// SPI receive-path frame sequencer: addresses splitter words into the receive buffer and
// holds each frame until acknowledged. Optional watchdog abort: define SPI_FRAME_TIMEOUT_EN.
module spi_frame_sequencer #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned BUF_ADDR_WIDTH = 4,
   parameter int unsigned FRAME_WORDS    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cs,
   input  logic                      word_ready,
   input  logic [DATA_WIDTH-1:0]     word_in,
   output logic                      splitter_rst,
   output logic                      buf_we,
   output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
   output logic [DATA_WIDTH-1:0]     buf_data,
   output logic                      frame_ready,
   output logic [BUF_ADDR_WIDTH:0]   frame_words,
   input  logic                      frame_ack,
   output logic                      overflow,
   output logic                      timeout
);

   localparam int unsigned CntWidth = BUF_ADDR_WIDTH + 1;
   localparam logic [CntWidth-1:0] FrameMax = CntWidth'(FRAME_WORDS);

   // StAbort is only reachable when the watchdog is built.
   typedef enum logic [1:0] {StIdle, StRecv, StHold, StAbort} state_e;

   state_e                    state_q, state_d;
   logic [CntWidth-1:0]       count_q, count_d, count_inc;
   logic                      ack_pending_q, ack_pending_d;
   logic                      splitter_rst_d, buf_we_d, frame_ready_d, overflow_d, timeout_d;
   logic [BUF_ADDR_WIDTH-1:0] buf_addr_d;
   logic [DATA_WIDTH-1:0]     buf_data_d;
   logic [CntWidth-1:0]       frame_words_d;

`ifdef SPI_FRAME_TIMEOUT_EN
   localparam int unsigned IdleWidth = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [IdleWidth-1:0] IdleMax = IdleWidth'(TIMEOUT_CYCLES - 1);

   logic [IdleWidth-1:0] idle_q, idle_d;
   logic                 idle_hit;

   assign idle_hit = (idle_q == IdleMax);
   // Counts quiet cycles inside RECV; any other state leaves it at zero for the next entry.
   assign idle_d = (state_q == StRecv && !cs && !word_ready && !idle_hit) ?
                   idle_q + 1'b1 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_q <= '0;
      else     idle_q <= idle_d;
   end
`endif

   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      ack_pending_d  = ack_pending_q;
      splitter_rst_d = splitter_rst;
      buf_we_d       = 1'b0;
      buf_addr_d     = buf_addr;
      buf_data_d     = buf_data;
      frame_ready_d  = frame_ready;
      frame_words_d  = frame_words;
      overflow_d     = overflow;
      timeout_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            splitter_rst_d = 1'b1;
            if (!cs) begin
               state_d        = StRecv;
               count_d        = '0;
               splitter_rst_d = 1'b0;
            end
         end
         StRecv: begin
            splitter_rst_d = 1'b0;
            if (word_ready) begin
               buf_we_d   = 1'b1;
               buf_addr_d = count_q[BUF_ADDR_WIDTH-1:0];
               buf_data_d = word_in;
               count_d    = count_inc;
               // A word coinciding with cs release still belongs to the closing frame.
               if (count_inc == FrameMax || cs) begin
                  state_d        = StHold;
                  frame_ready_d  = 1'b1;
                  frame_words_d  = count_inc;
                  splitter_rst_d = cs;
               end
            end else if (cs) begin
               splitter_rst_d = 1'b1;
               if (count_q != '0) begin
                  state_d       = StHold;
                  frame_ready_d = 1'b1;
                  frame_words_d = count_q;
               end else begin
                  state_d = StIdle;
               end
            end
`ifdef SPI_FRAME_TIMEOUT_EN
            else if (idle_hit) begin
               state_d        = StAbort;
               timeout_d      = 1'b1;
               count_d        = '0;
               splitter_rst_d = 1'b1;
            end
`endif
         end
         StHold: begin
            splitter_rst_d = cs;
            if (word_ready) overflow_d = 1'b1;
            if ((frame_ack || ack_pending_q) && cs) begin
               state_d        = StIdle;
               frame_ready_d  = 1'b0;
               frame_words_d  = '0;
               overflow_d     = 1'b0;
               ack_pending_d  = 1'b0;
               splitter_rst_d = 1'b1;
            end else if (frame_ack) begin
               ack_pending_d = 1'b1;
            end
         end
         StAbort: begin
            splitter_rst_d = 1'b1;
            count_d        = '0;
            if (cs) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         count_q       <= '0;
         ack_pending_q <= 1'b0;
         splitter_rst  <= 1'b1;
         buf_we        <= 1'b0;
         buf_addr      <= '0;
         buf_data      <= '0;
         frame_ready   <= 1'b0;
         frame_words   <= '0;
         overflow      <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         ack_pending_q <= ack_pending_d;
         splitter_rst  <= splitter_rst_d;
         buf_we        <= buf_we_d;
         buf_addr      <= buf_addr_d;
         buf_data      <= buf_data_d;
         frame_ready   <= frame_ready_d;
         frame_words   <= frame_words_d;
         overflow      <= overflow_d;
         timeout       <= timeout_d;
      end
   end

endmodule
